// File: rtl/ifetch_ctrl_pkg.sv
// Shared widths, constants and FSM state type for the IF-stage fetch sequencer.
package ifetch_ctrl_pkg;

   localparam int PC_SIZE    = 32;
   localparam int INSTR_SIZE = 32;

   // addi x0, x0, 0 -- presented to predecode whenever nothing valid is held
   localparam logic [INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_VALID = 3'd3,
      ST_DRAIN = 3'd4
   } ifc_state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request/response channel between the fetch sequencer and imem.
interface ifetch_ctrl_if
   import ifetch_ctrl_pkg::*;
();

   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [PC_SIZE-1:0]    imem_req_addr;
   logic                  imem_rsp_valid;
   logic [INSTR_SIZE-1:0] imem_rsp_instr;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_instr
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_instr
   );

endinterface

// File: rtl/ifetch_ctrl_kill_cnt.sv
// Saturating count of fetches discarded because of a redirect.
module ifetch_ctrl_kill_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // count up on each discarded fetch, stick at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer for the IF stage: owns the fetch PC, keeps one imem request in
// flight at most, holds the returned instruction for predecode/ID and throws away
// fetches made stale by a predecode redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | first cycle after reset, nothing requested yet
// ST_REQ   | request presented at pc_q, waiting for imem ready
// ST_WAIT  | request accepted, response still wanted
// ST_VALID | instruction held for predecode/ID
// ST_DRAIN | request accepted but redirected; one response owed, discard it
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [PC_SIZE-1:0] RESET_PC = '0,
   parameter int                 CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   ifetch_ctrl_if.master         imem,
   output logic                  if_valid,
   output logic [INSTR_SIZE-1:0] if_instr,
   output logic [PC_SIZE-1:0]    if_pc,
   input  logic                  id_stall,
   input  logic [PC_SIZE-1:0]    pd_pc_next,
   input  logic                  pd_nop_sel,
   output logic [CNT_W-1:0]      killed_cnt
);

   ifc_state_e            state_q, state_d;
   logic [PC_SIZE-1:0]    pc_q, pc_d;
   logic [INSTR_SIZE-1:0] instr_q, instr_d;
   logic [PC_SIZE-1:0]    ifpc_q, ifpc_d;
   logic                  kill_inc;

   // state, fetch PC and held-instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= INSTR_NOP;
         ifpc_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
      end
   end

   // next-state, PC update and kill strobe; a redirect always wins over consumption
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      ifpc_d   = ifpc_q;
      kill_inc = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            // the address may move while imem is not ready; only valid&ready is sampled
            if (pd_nop_sel) pc_d = pd_pc_next;
            if (imem.imem_req_ready) state_d = pd_nop_sel ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            if (imem.imem_rsp_valid) begin
               if (pd_nop_sel) begin
                  pc_d     = pd_pc_next;
                  kill_inc = 1'b1;
                  state_d  = ST_REQ;
               end else begin
                  instr_d = imem.imem_rsp_instr;
                  ifpc_d  = pc_q;
                  state_d = ST_VALID;
               end
            end else if (pd_nop_sel) begin
               pc_d    = pd_pc_next;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pd_nop_sel) pc_d = pd_pc_next;
            if (imem.imem_rsp_valid) begin
               kill_inc = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_VALID: begin
            if (pd_nop_sel) begin
               pc_d     = pd_pc_next;
               kill_inc = 1'b1;
               state_d  = ST_REQ;
            end else if (!id_stall) begin
               pc_d    = pd_pc_next;
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   ifetch_ctrl_kill_cnt #(
      .CNT_W (CNT_W)
   ) u_kill_cnt (
      .clk (clk),
      .rst (rst),
      .inc (kill_inc),
      .cnt (killed_cnt)
   );

   assign imem.imem_req_valid = (state_q == ST_REQ);
   assign imem.imem_req_addr  = pc_q;
   assign if_valid            = (state_q == ST_VALID);
   assign if_instr            = if_valid ? instr_q : INSTR_NOP;
   assign if_pc               = ifpc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_ifetch_ctrl;
   import ifetch_ctrl_pkg::*;

   localparam int                 CNT_W  = 4;
   localparam int                 KMAX   = (1 << CNT_W) - 1;
   localparam logic [PC_SIZE-1:0] RST_PC = '0;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  if_valid;
   logic [INSTR_SIZE-1:0] if_instr;
   logic [PC_SIZE-1:0]    if_pc;
   logic                  id_stall;
   logic [PC_SIZE-1:0]    pd_pc_next;
   logic                  pd_nop_sel;
   logic [CNT_W-1:0]      killed_cnt;

   ifetch_ctrl_if imem ();

   ifetch_ctrl #(
      .RESET_PC (RST_PC),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem       (imem),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .id_stall   (id_stall),
      .pd_pc_next (pd_pc_next),
      .pd_nop_sel (pd_nop_sel),
      .killed_cnt (killed_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: "requests whenever nothing is held and no response is owed"
   bit                    m_boot, m_held, m_owed, m_live;
   logic [PC_SIZE-1:0]    m_pc, m_ifpc;
   logic [INSTR_SIZE-1:0] m_instr;
   int                    m_killed;

   task automatic model_kill();
      if (m_killed < KMAX) m_killed++;
   endtask

   task automatic model_step();
      if (rst) begin
         m_boot = 1; m_held = 0; m_owed = 0; m_live = 0;
         m_pc = RST_PC; m_ifpc = RST_PC; m_instr = INSTR_NOP; m_killed = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_held) begin
         if (pd_nop_sel) begin
            m_held = 0; m_pc = pd_pc_next; model_kill();
         end else if (!id_stall) begin
            m_held = 0; m_pc = pd_pc_next;
         end
      end else if (m_owed) begin
         if (imem.imem_rsp_valid) begin
            m_owed = 0;
            if (m_live && !pd_nop_sel) begin
               m_held = 1; m_instr = imem.imem_rsp_instr; m_ifpc = m_pc;
            end else begin
               model_kill();
               if (pd_nop_sel) m_pc = pd_pc_next;
            end
         end else if (pd_nop_sel) begin
            m_pc = pd_pc_next; m_live = 0;
         end
      end else begin
         if (imem.imem_req_ready) begin
            m_owed = 1; m_live = !pd_nop_sel;
         end
         if (pd_nop_sel) m_pc = pd_pc_next;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // from REQ: accept the request, return instr next cycle, land in VALID
   task automatic fetch_to_valid(input logic [INSTR_SIZE-1:0] instr);
      imem.imem_req_ready = 1'b1;
      cycle();
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_instr = instr;
      cycle();
      imem.imem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      total++; if (imem.imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem.imem_req_valid); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
      total++; if (if_instr !== INSTR_NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", if_instr, INSTR_NOP); end
      total++; if (if_pc !== RST_PC) begin bad++; $display("FAIL reset_if_pc got=%h want=%h", if_pc, RST_PC); end
      total++; if (imem.imem_req_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem.imem_req_addr, RST_PC); end
      total++; if (killed_cnt !== '0) begin bad++; $display("FAIL reset_killed got=%0d want=0", killed_cnt); end
      rst = 1'b0;
   endtask

   task automatic test_first_fetch();
      imem.imem_req_ready = 1'b1;
      cycle();
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%b/%h want=1/0", imem.imem_req_valid, imem.imem_req_addr); end
      cycle();
      imem.imem_req_ready = 1'b0;
      total++; if (imem.imem_req_valid !== 1'b0) begin bad++; $display("FAIL first_wait_req got=%b want=0", imem.imem_req_valid); end
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_instr = 32'h0000_0013;
      cycle();
      imem.imem_rsp_valid = 1'b0;
      total++; if (if_valid !== 1'b1 || if_instr !== 32'h13 || if_pc !== 32'h0) begin bad++; $display("FAIL first_valid got=%b/%h/%h want=1/00000013/0", if_valid, if_instr, if_pc); end
      id_stall   = 1'b0;
      pd_pc_next = 32'h4;
      cycle();
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h4) begin bad++; $display("FAIL first_next_req got=%b/%h want=1/4", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_stall();
      fetch_to_valid(32'hDEAD_BEEF);
      id_stall   = 1'b1;
      pd_pc_next = 32'h888;
      for (int i = 0; i < 5; i++) begin
         cycle();
         total++; if (if_valid !== 1'b1 || if_instr !== 32'hDEAD_BEEF || if_pc !== 32'h4 || imem.imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%h/req%b want=1/deadbeef/4/req0", i, if_valid, if_instr, if_pc, imem.imem_req_valid);
         end
      end
      id_stall = 1'b0;
      cycle();
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h888) begin bad++; $display("FAIL stall_release got=%b/%h want=1/888", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_jal();
      fetch_to_valid($urandom);
      pd_pc_next = 32'h100;
      cycle();
      fetch_to_valid(32'h0800_006F);
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin bad++; $display("FAIL jal_held got=%b/%h want=1/100", if_valid, if_pc); end
      pd_pc_next = 32'h180;
      cycle();
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h180) begin bad++; $display("FAIL jal_target got=%b/%h want=1/180", imem.imem_req_valid, imem.imem_req_addr); end
      total++; if (killed_cnt !== '0) begin bad++; $display("FAIL jal_killed got=%0d want=0", killed_cnt); end
   endtask

   task automatic test_redirect_wait();
      imem.imem_req_ready = 1'b1;
      cycle();
      imem.imem_req_ready = 1'b0;
      pd_nop_sel = 1'b1;
      pd_pc_next = 32'h200;
      cycle();
      pd_nop_sel = 1'b0;
      for (int i = 0; i < 2; i++) begin
         total++; if (if_valid !== 1'b0 || imem.imem_req_valid !== 1'b0) begin bad++; $display("FAIL drain_idle[%0d] got=%b/req%b want=0/req0", i, if_valid, imem.imem_req_valid); end
         cycle();
      end
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_instr = $urandom;
      cycle();
      imem.imem_rsp_valid = 1'b0;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL drain_dropped got=%b want=0", if_valid); end
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h200) begin bad++; $display("FAIL drain_next_req got=%b/%h want=1/200", imem.imem_req_valid, imem.imem_req_addr); end
      total++; if (killed_cnt !== 4'd1) begin bad++; $display("FAIL drain_killed got=%0d want=1", killed_cnt); end
   endtask

   task automatic test_redirect_same_cycle();
      imem.imem_req_ready = 1'b1;
      cycle();
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_instr = $urandom;
      pd_nop_sel = 1'b1;
      pd_pc_next = 32'h40;
      cycle();
      imem.imem_rsp_valid = 1'b0;
      pd_nop_sel = 1'b0;
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h40 || if_valid !== 1'b0) begin bad++; $display("FAIL same_cycle got=%b/%h/v%b want=1/40/v0", imem.imem_req_valid, imem.imem_req_addr, if_valid); end
      total++; if (killed_cnt !== 4'd2) begin bad++; $display("FAIL same_cycle_killed got=%0d want=2", killed_cnt); end
      pd_nop_sel = 1'b1;
      pd_pc_next = 32'h60;
      cycle();
      pd_nop_sel = 1'b0;
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h60) begin bad++; $display("FAIL req_retarget got=%b/%h want=1/60", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_saturate();
      logic [PC_SIZE-1:0] tgt;
      int                 want;
      for (int i = 0; i < 16; i++) begin
         imem.imem_req_ready = 1'b1;
         cycle();
         imem.imem_req_ready = 1'b0;
         tgt = $urandom;
         imem.imem_rsp_valid = 1'b1;
         imem.imem_rsp_instr = $urandom;
         pd_nop_sel = 1'b1;
         pd_pc_next = tgt;
         cycle();
         imem.imem_rsp_valid = 1'b0;
         pd_nop_sel = 1'b0;
         want = (i + 3 > KMAX) ? KMAX : i + 3;
         total++; if (killed_cnt !== CNT_W'(want) || imem.imem_req_addr !== tgt) begin
            bad++; $display("FAIL saturate[%0d] got=%0d/%h want=%0d/%h", i, killed_cnt, imem.imem_req_addr, want, tgt);
         end
      end
   endtask

   task automatic test_reset_in_drain();
      imem.imem_req_ready = 1'b1;
      pd_nop_sel = 1'b1;
      pd_pc_next = 32'h300;
      cycle();
      imem.imem_req_ready = 1'b0;
      pd_nop_sel = 1'b0;
      total++; if (imem.imem_req_valid !== 1'b0 || imem.imem_req_addr !== 32'h300) begin bad++; $display("FAIL drain_entry got=%b/%h want=0/300", imem.imem_req_valid, imem.imem_req_addr); end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      total++; if (imem.imem_req_valid !== 1'b0 || imem.imem_req_addr !== RST_PC || killed_cnt !== '0 || if_valid !== 1'b0) begin
         bad++; $display("FAIL drain_reset got=%b/%h/%0d/%b want=0/%h/0/0", imem.imem_req_valid, imem.imem_req_addr, killed_cnt, if_valid, RST_PC);
      end
      cycle();
      total++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== RST_PC) begin bad++; $display("FAIL drain_reboot got=%b/%h want=1/%h", imem.imem_req_valid, imem.imem_req_addr, RST_PC); end
   endtask

   task automatic test_random();
      bit                    exp_req;
      logic [INSTR_SIZE-1:0] exp_instr;
      for (int i = 0; i < 3000; i++) begin
         exp_req   = !m_boot && !m_held && !m_owed;
         exp_instr = m_held ? m_instr : INSTR_NOP;
         total++; if (imem.imem_req_valid !== exp_req || imem.imem_req_addr !== m_pc) begin
            bad++; $display("FAIL rnd_req[%0d] got=%b/%h want=%b/%h", i, imem.imem_req_valid, imem.imem_req_addr, exp_req, m_pc);
         end
         total++; if (if_valid !== m_held || if_instr !== exp_instr || if_pc !== m_ifpc) begin
            bad++; $display("FAIL rnd_held[%0d] got=%b/%h/%h want=%b/%h/%h", i, if_valid, if_instr, if_pc, m_held, exp_instr, m_ifpc);
         end
         total++; if (killed_cnt !== CNT_W'(m_killed)) begin
            bad++; $display("FAIL rnd_killed[%0d] got=%0d want=%0d", i, killed_cnt, m_killed);
         end
         rst                 = ($urandom_range(0, 199) == 0);
         imem.imem_req_ready = ($urandom_range(0, 3) != 0);
         imem.imem_rsp_valid = m_owed && ($urandom_range(0, 2) == 0);
         imem.imem_rsp_instr = $urandom;
         id_stall            = ($urandom_range(0, 2) == 0);
         pd_nop_sel          = ($urandom_range(0, 5) == 0);
         pd_pc_next          = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 7))) : 32'($urandom);
         cycle();
      end
      rst = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      pd_nop_sel = 1'b0;
   endtask

   initial begin
      rst                 = 1'b1;
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_instr = '0;
      id_stall            = 1'b0;
      pd_pc_next          = '0;
      pd_nop_sel          = 1'b0;
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_stall();
      test_jal();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_saturate();
      test_reset_in_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired before test sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
